// File: rtl/router_pkt_tx_if.sv
// Host/router-side signal bundle for router_pkt_tx.
//   slave  : the transmitter (router_pkt_tx) view
//   master : the host/test view that drives writes, start, dest_addr and busy
// Signals:
//   wr_en, wr_data            payload buffer write
//   start, dest_addr          send request and destination port (3 illegal)
//   busy                      router stall
//   pkt_valid, data_out       byte-serial stream to the router
//   tx_active, done           status: not idle / parity accepted pulse
//   start_err, wr_drop        rejected start / discarded write pulses
//   wr_count                  bytes currently buffered
interface router_pkt_tx_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       start;
  logic [1:0] dest_addr;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_active;
  logic       done;
  logic       start_err;
  logic       wr_drop;
  logic [5:0] wr_count;

  modport slave (
    input  wr_en, wr_data, start, dest_addr, busy,
    output pkt_valid, data_out, tx_active, done, start_err, wr_drop, wr_count
  );

  modport master (
    output wr_en, wr_data, start, dest_addr, busy,
    input  pkt_valid, data_out, tx_active, done, start_err, wr_drop, wr_count
  );
endinterface

// File: rtl/router_pkt_tx.sv
// Packet source for a router input port. Buffers up to 63 payload bytes, then
// sends header {len, addr}, the payload and a trailing XOR parity byte with
// pkt_valid framing, honouring the router's busy stall. All outputs registered.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-high reset
//   bus    router_pkt_tx_if.slave (write port, start request, stream, status)
// Parameters:
//   IDLE_GAP  idle cycles after each parity byte before IDLE (minimum 1)
module router_pkt_tx #(
  parameter int unsigned IDLE_GAP = 2
) (
  input  logic           clock,
  input  logic           reset,
  router_pkt_tx_if.slave bus
);

  localparam int unsigned GapW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'(IDLE_GAP - 1);

  typedef enum logic [2:0] {StIdle, StHeader, StPayload, StParity, StGap} state_e;

  state_e          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [5:0]      len_q, len_d;
  logic [5:0]      idx_q, idx_d;
  logic [7:0]      par_q, par_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [7:0]      dout_q, dout_d;
  logic            pv_q, pv_d;
  logic            act_q, act_d;
  logic            done_q, done_d;
  logic            serr_q, serr_d;
  logic            drop_q, drop_d;
  logic            mem_we;
  logic [7:0]      mem_q [64];

  // Payload storage has no reset; its contents are irrelevant after reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[cnt_q] <= bus.wr_data;
    end
  end

  // Outputs are computed for the next state so the registered value lines up
  // with the state being entered (header appears on the start-accept edge).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    idx_d   = idx_q;
    par_d   = par_q;
    gap_d   = gap_q;
    dout_d  = dout_q;
    pv_d    = pv_q;
    done_d  = 1'b0;
    serr_d  = 1'b0;
    drop_d  = 1'b0;
    mem_we  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (cnt_q == 6'd0 || bus.dest_addr == 2'd3) begin
            serr_d = 1'b1;
          end else begin
            state_d = StHeader;
            len_d   = cnt_q;
            dout_d  = {cnt_q, bus.dest_addr};
            pv_d    = 1'b1;
          end
        end
        // A write alongside start is always dropped, whatever start's outcome.
        if (bus.wr_en) begin
          if (bus.start || cnt_q == 6'd63) begin
            drop_d = 1'b1;
          end else begin
            mem_we = 1'b1;
            cnt_d  = cnt_q + 6'd1;
          end
        end
      end
      StHeader: begin
        if (!bus.busy) begin
          par_d   = dout_q;
          idx_d   = 6'd0;
          dout_d  = mem_q[0];
          state_d = StPayload;
        end
      end
      StPayload: begin
        if (!bus.busy) begin
          par_d = par_q ^ dout_q;
          idx_d = idx_q + 6'd1;
          if (idx_q == len_q - 6'd1) begin
            state_d = StParity;
            dout_d  = par_q ^ dout_q;
            pv_d    = 1'b0;
          end else begin
            dout_d = mem_q[idx_q + 6'd1];
          end
        end
      end
      StParity: begin
        if (!bus.busy) begin
          state_d = StGap;
          done_d  = 1'b1;
          cnt_d   = 6'd0;
          dout_d  = 8'h00;
          gap_d   = '0;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle && bus.wr_en) begin
      drop_d = 1'b1;
    end

    act_d = (state_d != StIdle);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 6'd0;
      len_q   <= 6'd0;
      idx_q   <= 6'd0;
      par_q   <= 8'h00;
      gap_q   <= '0;
      dout_q  <= 8'h00;
      pv_q    <= 1'b0;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
      serr_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      gap_q   <= gap_d;
      dout_q  <= dout_d;
      pv_q    <= pv_d;
      act_q   <= act_d;
      done_q  <= done_d;
      serr_q  <= serr_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.pkt_valid = pv_q;
  assign bus.data_out  = dout_q;
  assign bus.tx_active = act_q;
  assign bus.done      = done_q;
  assign bus.start_err = serr_q;
  assign bus.wr_drop   = drop_q;
  assign bus.wr_count  = cnt_q;

endmodule
